range_max_scan: RTL and testbench
=================================

Name: range_max_scan

Overview:
- Controller sitting directly downstream of the range block. It drives range's go/start inputs and consumes its done/count outputs.
- On request it launches one range run from a base number, waits for completion, then reads back all RAM_WORDS stored iteration counts.
- It reports the largest count and which starting number produced it, for display or software readout.

Parameters:
RAM_WORDS, 16, number of counts range stores; must match the attached range instance
RAM_ADDR_BITS, 4, range RAM address width; RAM_WORDS == 2**RAM_ADDR_BITS

Ports:
clk  input  1  clock
reset_n  input  1  synchronous active-low reset
req  input  1  single-cycle start request; sampled only in IDLE
base  input  32  first number of the range; captured on accepted req
busy  output  1  high from accepted req until result valid
valid  output  1  high while result registers hold a completed result
max_count  output  16  largest iteration count found
max_idx  output  RAM_ADDR_BITS  RAM index of max_count
max_n  output  32  starting number for max_count = base_q + max_idx
rg_go  output  1  to range go
rg_start  output  32  to range start (base during launch, read address during readback)
rg_done  input  1  from range done
rg_count  input  16  from range count (registered: address at cycle t gives data at t+1)

Behaviour:
- One clock domain. Reset is synchronous and active-low: reset_n is sampled on the rising edge of clk, and reset_n = 0 forces the reset state.
- Reset state:
  - state = IDLE
  - busy = 0, valid = 0, rg_go = 0, rg_start = 0
  - max_count = 0, max_idx = 0, max_n = 0
  - internal base_q = 0, address counter = 0
- States: IDLE, LAUNCH, WAIT, READ, FLUSH, RESULT.
- IDLE:
  - req = 1: capture base into base_q, clear valid, busy <= 1, go to LAUNCH.
  - req = 0: stay in IDLE.
- LAUNCH (exactly 1 cycle): rg_go = 1, rg_start = base_q; next state WAIT.
- WAIT:
  - rg_go = 0, rg_start = base_q.
  - rg_done is evaluated only from the first WAIT cycle onward, when range has already cleared done.
  - Go to READ on the first cycle with rg_done = 1. No timeout.
- READ:
  - rg_go = 0. rg_start = zero-extended address counter a, with a running 0 .. RAM_WORDS-1, one per cycle.
  - Compare pipeline: a 1-cycle-delayed copy of a and a delayed valid flag qualify rg_count. The first qualified sample loads max_count/max_idx unconditionally.
  - Later samples replace the held values only if rg_count > max_count. Strict compare, so ties keep the lowest index.
  - After a = RAM_WORDS-1 is issued, go to FLUSH.
- FLUSH (1 cycle):
  - Compare the final sample.
  - max_n <= base_q + max_idx, with max_idx zero-extended; 32-bit add, wraps modulo 2^32.
  - Next state RESULT.
- RESULT (1 cycle): valid <= 1, busy <= 0, next state IDLE.
- valid stays high until the next accepted req.
- Latency:
  - req to rg_go: 1 cycle.
  - rg_done seen to valid: RAM_WORDS + 2 cycles.
- Boundaries and corner cases:
  - req while busy is ignored, with no queuing.
  - req held high continuously retriggers a new scan each time IDLE is re-entered.
  - base = 32'hFFFF_FFF8: max_n wraps (e.g. idx 9 gives 32'h0000_0001).
  - All counts equal: max_idx = 0.
  - Max in the last word (idx RAM_WORDS-1) must be captured via FLUSH.
  - rg_done dropping during READ is not possible by construction (range only clears done on go); it is not checked.
- Reset mid-operation: returns to IDLE immediately and clears all outputs.
- Integration restriction: range has no reset. The integrator must not issue req after a mid-run reset until the interrupted range run has completed.

Test Plan:
- Reset: hold reset_n = 0 for 3 cycles, any req/base -> busy = 0, valid = 0, rg_go = 0, max_* = 0.
- Basic run, base = 1, real range + collatz attached -> range stores counts for 1..16. Max is 19 steps at n = 9 (collatz(9)), so max_count = 19, max_idx = 8, max_n = 9.
- Tie and last-word behaviour, behavioural range model:
  - counts all 5 -> max_idx = 0.
  - count[15] = 100, others 3 -> max_idx = 15, max_n = base + 15.
- Timing: model asserts rg_done 40 cycles after rg_go. Check all of:
  - rg_go is high for exactly 1 cycle, 1 cycle after req.
  - rg_start walks 0..15 on consecutive cycles.
  - valid rises exactly 18 cycles after rg_done.
- Protocol: req pulsed during WAIT and during READ -> ignored, a single rg_go pulse per scan; valid then persists until the next req, which drops valid the following cycle.
- Wrap and abort:
  - base = 32'hFFFF_FFF8 with max at idx 9 -> max_n = 32'h0000_0001.
  - reset_n = 0 mid-READ -> IDLE next cycle, outputs cleared. A later req after the model is idle gives a correct result.

Source files
------------

// File: rtl/range_max_scan.sv
// range_max_scan: runs one range scan from a base number, reads back every stored count and reports the largest one.
// Ports:
//   clk, reset_n        clock and synchronous active-low reset
//   req, base           start request (accepted only in IDLE) and first number of the range
//   busy, valid         scan in progress / result registers hold a completed result
//   max_count, max_idx  largest count read back and the RAM index holding it
//   max_n               starting number that produced max_count (base + max_idx, mod 2^32)
//   rg_go, rg_start     drive the attached range block (launch pulse, then base or read address)
//   rg_done, rg_count   range completion flag and its registered RAM read data
module range_max_scan #(
    parameter int RAM_WORDS     = 16,
    parameter int RAM_ADDR_BITS = 4
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     req,
    input  logic [31:0]              base,
    output logic                     busy,
    output logic                     valid,
    output logic [15:0]              max_count,
    output logic [RAM_ADDR_BITS-1:0] max_idx,
    output logic [31:0]              max_n,
    output logic                     rg_go,
    output logic [31:0]              rg_start,
    input  logic                     rg_done,
    input  logic [15:0]              rg_count
);
    typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, READ, FLUSH, RESULT} state_t;
    state_t                   r_state, w_next;
    logic                     r_busy, r_valid, r_first, r_pv;
    logic [31:0]              r_base_q, r_max_n;
    logic [RAM_ADDR_BITS-1:0] r_addr, r_pa, r_max_idx, w_idx;
    logic [15:0]              r_max_count;
    logic                     w_take;
    always_ff @(posedge clk)
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_next;
    always_comb begin
        w_next   = r_state;
        rg_go    = 1'b0;
        rg_start = '0;
        case (r_state)
            IDLE:   w_next = req ? LAUNCH : IDLE;
            LAUNCH: begin
                w_next   = WAIT;
                rg_go    = 1'b1;
                rg_start = r_base_q;
            end
            WAIT:   begin
                w_next   = rg_done ? READ : WAIT;
                rg_start = r_base_q;
            end
            READ:   begin
                w_next   = (r_addr == RAM_ADDR_BITS'(RAM_WORDS - 1)) ? FLUSH : READ;
                rg_start = 32'(r_addr);
            end
            FLUSH:  w_next = RESULT;
            RESULT: w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end
    // r_pv/r_pa trail the issued address by one cycle to line up with the registered RAM data;
    // the first qualified sample of a scan always loads, later ones only on a strictly larger count.
    assign w_take = r_pv && (r_first || rg_count > r_max_count);
    assign w_idx  = w_take ? r_pa : r_max_idx;
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_busy      <= 1'b0;
            r_valid     <= 1'b0;
            r_first     <= 1'b0;
            r_pv        <= 1'b0;
            r_pa        <= '0;
            r_addr      <= '0;
            r_base_q    <= '0;
            r_max_count <= '0;
            r_max_idx   <= '0;
            r_max_n     <= '0;
        end else begin
            r_pv <= (r_state == READ);
            r_pa <= r_addr;
            if (r_state == IDLE && req) begin
                r_base_q <= base;
                r_valid  <= 1'b0;
                r_busy   <= 1'b1;
                r_first  <= 1'b1;
            end
            // wraps back to 0 after the last word, ready for the next scan
            if (r_state == READ) r_addr <= r_addr + 1'b1;
            if (w_take) begin
                r_max_count <= rg_count;
                r_max_idx   <= r_pa;
                r_first     <= 1'b0;
            end
            // FLUSH also compares the last word, so use the index as updated this cycle
            if (r_state == FLUSH) r_max_n <= r_base_q + 32'(w_idx);
            if (r_state == RESULT) begin
                r_valid <= 1'b1;
                r_busy  <= 1'b0;
            end
        end
    end
    assign busy      = r_busy;
    assign valid     = r_valid;
    assign max_count = r_max_count;
    assign max_idx   = r_max_idx;
    assign max_n     = r_max_n;
endmodule

// File: tb/tb_range_max_scan.sv
// tb_range_max_scan: scoreboard bench for range_max_scan driving a behavioural range model.
module tb_range_max_scan;
    logic        clk = 1'b0;
    logic        reset_n, req;
    logic [31:0] base;
    logic        busy, valid, rg_go, rg_done;
    logic [15:0] max_count, rg_count;
    logic [3:0]  max_idx;
    logic [31:0] max_n, rg_start;
    typedef struct {logic [15:0] c; logic [3:0] i; logic [31:0] n;} exp_t;
    exp_t        exp_q[$];
    logic [15:0] mem[16];
    int          n_cmp = 0, n_bad = 0, go_pulses = 0, dly = 10, m_cnt = 0;
    logic        m_run = 1'b0, pv_valid = 1'b0;
    range_max_scan #(.RAM_WORDS(16), .RAM_ADDR_BITS(4)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .base(base), .busy(busy), .valid(valid),
        .max_count(max_count), .max_idx(max_idx), .max_n(max_n), .rg_go(rg_go),
        .rg_start(rg_start), .rg_done(rg_done), .rg_count(rg_count)
    );
    always #5 clk = ~clk;
    // range model: done clears on go and rises dly cycles later; count is a registered RAM read
    always @(posedge clk) begin
        rg_count <= mem[rg_start[3:0]];
        if (rg_go) begin
            rg_done <= 1'b0;
            m_run   <= 1'b1;
            m_cnt   <= dly;
            go_pulses <= go_pulses + 1;
        end else if (m_run) begin
            if (m_cnt <= 1) begin
                rg_done <= 1'b1;
                m_run   <= 1'b0;
            end else m_cnt <= m_cnt - 1;
        end
    end
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask
    task automatic push(input logic [15:0] c, input logic [3:0] i, input logic [31:0] n);
        exp_t e;
        e.c = c; e.i = i; e.n = n;
        exp_q.push_back(e);
    endtask
    always @(negedge clk) begin
        if (valid && !pv_valid) begin
            if (exp_q.size() == 0) chk("unexpected_valid", 1, 0);
            else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("max_count", 32'(max_count), 32'(e.c));
                chk("max_idx", 32'(max_idx), 32'(e.i));
                chk("max_n", max_n, e.n);
            end
        end
        pv_valid = valid;
    end
    function automatic logic [15:0] collatz(input int n);
        int s = 0;
        while (n != 1) begin
            n = (n % 2 == 0) ? n / 2 : 3 * n + 1;
            s++;
        end
        return 16'(s);
    endfunction
    task automatic fill(input logic [15:0] v);
        for (int i = 0; i < 16; i++) mem[i] = v;
    endtask
    // one full scan with cycle-accurate protocol checks; inj pulses req during WAIT and READ
    task automatic scan(input logic [31:0] b, input int d, input bit inj);
        int  g0, k, lat;
        bit  walk_ok;
        dly = d;
        g0 = go_pulses;
        req = 1'b1; base = b;
        @(posedge clk); #1 req = 1'b0;
        chk("go_after_req", 32'(rg_go), 1);
        chk("busy_on_accept", 32'(busy), 1);
        chk("valid_cleared", 32'(valid), 0);
        chk("start_launch", rg_start, b);
        @(posedge clk); #1 chk("go_width", 32'(rg_go), 0);
        if (inj) req = 1'b1;
        @(posedge clk); #1 req = 1'b0;
        k = 0;
        while (!rg_done && k < 500) begin
            @(posedge clk); #1 k++;
        end
        if (k >= 500) begin
            chk("done_timeout", 0, 1);
            return;
        end
        @(posedge clk); #1 walk_ok = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (rg_start !== 32'(i)) walk_ok = 1'b0;
            if (inj && i == 5) req = 1'b1;
            if (inj && i == 6) req = 1'b0;
            if (i < 15) begin
                @(posedge clk); #1;
            end
        end
        chk("start_walk", 32'(walk_ok), 1);
        lat = 15;
        while (!valid && lat < 100) begin
            @(posedge clk); #1 lat++;
        end
        chk("done_to_valid", 32'(lat), 18);
        chk("busy_done", 32'(busy), 0);
        chk("single_go", 32'(go_pulses - g0), 1);
    endtask
    initial begin
        int g0, rises, k;
        logic pv;
        reset_n = 1'b0; req = 1'b1; base = 32'hDEAD_BEEF; rg_done = 1'b0;
        fill(16'd0);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_valid", 32'(valid), 0);
        chk("rst_go", 32'(rg_go), 0);
        chk("rst_start", rg_start, 0);
        chk("rst_max_count", 32'(max_count), 0);
        chk("rst_max_idx", 32'(max_idx), 0);
        chk("rst_max_n", max_n, 0);
        reset_n = 1'b1; req = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) mem[i] = collatz(i + 1);
        push(16'd19, 4'd8, 32'd9);
        scan(32'd1, 10, 1'b0);
        fill(16'd5);
        push(16'd5, 4'd0, 32'd100);
        scan(32'd100, 6, 1'b0);
        fill(16'd3); mem[15] = 16'd100;
        push(16'd100, 4'd15, 32'h0000_100F);
        scan(32'h0000_1000, 8, 1'b0);
        for (int i = 0; i < 16; i++) mem[i] = 16'((i * 7) % 16 + 1);
        push(16'd16, 4'd9, 32'h0000_0209);
        scan(32'h0000_0200, 40, 1'b1);
        repeat (5) @(posedge clk);
        #1 chk("valid_hold", 32'(valid), 1);
        fill(16'd7); mem[9] = 16'd50;
        push(16'd50, 4'd9, 32'h0000_0001);
        scan(32'hFFFF_FFF8, 12, 1'b0);
        fill(16'd2); mem[3] = 16'd40; mem[11] = 16'd40;
        dly = 5; req = 1'b1; base = 32'h0000_0050;
        @(posedge clk); #1 req = 1'b0;
        k = 0;
        while (!rg_done && k < 500) begin
            @(posedge clk); #1 k++;
        end
        repeat (6) @(posedge clk);
        #1 reset_n = 1'b0;
        @(posedge clk); #1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_valid", 32'(valid), 0);
        chk("abort_start", rg_start, 0);
        chk("abort_max_count", 32'(max_count), 0);
        chk("abort_max_n", max_n, 0);
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        push(16'd40, 4'd3, 32'h0000_0053);
        scan(32'h0000_0050, 7, 1'b0);
        push(16'd40, 4'd3, 32'h0000_0053);
        push(16'd40, 4'd3, 32'h0000_0053);
        g0 = go_pulses; rises = 0; pv = valid; k = 0;
        dly = 4; req = 1'b1;
        while (rises < 2 && k < 400) begin
            @(posedge clk); #1 k++;
            if (valid && !pv) rises++;
            pv = valid;
        end
        req = 1'b0;
        chk("retrigger_runs", 32'(rises), 2);
        chk("retrigger_go", 32'(go_pulses - g0), 2);
        repeat (5) @(posedge clk);
        #1 chk("queue_drained", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
